uart_inst_loader: RTL and testbench

- Serial program loader: receives bytes on UART_RXD (8N1), packs them into 32-bit instruction words and writes them sequentially into instruction memory.
- It is the writer side of the instruction memory that the CPU datapath reads through its PC address port.
- Sits in Mod_Teste between UART_RXD and the write port of the instruction memory. The CPU is held in reset (KEY-driven) while busy=1 or done=0.

---
 rtl/uart_inst_loader_if.sv | 15 +
 rtl/uart_inst_loader.sv | 149 ++++++++++++++
 tb/tb_uart_inst_loader.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_inst_loader_if.sv
// Loader-side bundle: serial line and enable in; instruction-memory write port and status out.
interface uart_inst_loader_if #(parameter int ADDR_W = 8);
  logic              rx;
  logic              en;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              busy;
  logic              done;
  logic              frame_err;
  logic              chk_err;

  modport slave  (input rx, en, output wr_en, wr_addr, wr_data, busy, done, frame_err, chk_err);
  modport master (output rx, en, input wr_en, wr_addr, wr_data, busy, done, frame_err, chk_err);
endinterface

// File: rtl/uart_inst_loader.sv
// UART 8N1 program loader: packs bytes big-endian into 32-bit words and writes them to imem.
// Optional trailing XOR checksum byte enabled by defining LOADER_CHECKSUM_EN.
module uart_inst_loader #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD      = 115200,
  parameter int ADDR_W    = 8,
  parameter int NUM_WORDS = 256
) (
  input  logic               clk,
  input  logic               rst,
  uart_inst_loader_if.slave  bus
);
  localparam int CPB  = CLK_FREQ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB + 1);
  localparam int WCW  = $clog2(NUM_WORDS + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic              r_sync1, r_rx_s;
  logic [1:0]        r_state;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_bit;
  logic [7:0]        r_shift;
  logic [1:0]        r_idx;
  logic [23:0]       r_word;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wr_data;
  logic [WCW-1:0]    r_wcnt;
  logic              r_done;
  logic              r_ferr;
  logic              w_tick, w_half, w_ck_phase;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] r_xor;
  logic       r_chk_err;
  assign w_ck_phase  = (r_wcnt == WCW'(NUM_WORDS));
  assign bus.chk_err = r_chk_err;
`else
  assign w_ck_phase  = 1'b0;
  assign bus.chk_err = 1'b0;
`endif

  assign w_tick = (r_cnt == CW'(CPB - 1));
  assign w_half = (r_cnt == CW'(HALF - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      r_sync1 <= bus.rx;
      r_rx_s  <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_idx     <= '0;
      r_word    <= '0;
      r_wr_en   <= 1'b0;
      r_addr    <= '0;
      r_wr_data <= '0;
      r_wcnt    <= '0;
      r_done    <= 1'b0;
      r_ferr    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_xor     <= '0;
      r_chk_err <= 1'b0;
`endif
    end else begin
      r_wr_en <= 1'b0;
      // Dropping en abandons the frame and any partial word, but keeps the address.
      if (!bus.en) begin
        r_state <= S_IDLE;
        r_idx   <= '0;
      end else begin
        case (r_state)
          S_IDLE: if (!r_rx_s && !r_done) begin
            r_state <= S_START;
            r_cnt   <= '0;
          end
          S_START: if (w_half) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_state <= r_rx_s ? S_IDLE : S_DATA;
          end else r_cnt <= r_cnt + CW'(1);
          S_DATA: if (w_tick) begin
            r_cnt   <= '0;
            r_shift <= {r_rx_s, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) r_state <= S_STOP;
          end else r_cnt <= r_cnt + CW'(1);
          S_STOP: if (w_tick) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            if (!r_rx_s) begin
              r_ferr <= 1'b1;
              r_idx  <= '0;
            end else if (w_ck_phase) begin
`ifdef LOADER_CHECKSUM_EN
              r_done    <= 1'b1;
              r_chk_err <= (r_shift != r_xor);
`endif
            end else begin
              r_idx <= r_idx + 2'd1;
              case (r_idx)
                2'd0: r_word[23:16] <= r_shift;
                2'd1: r_word[15:8]  <= r_shift;
                2'd2: r_word[7:0]   <= r_shift;
                default: begin
                  r_wr_en   <= 1'b1;
                  r_wr_data <= {r_word, r_shift};
`ifdef LOADER_CHECKSUM_EN
                  r_xor <= r_xor ^ r_word[23:16] ^ r_word[15:8] ^ r_word[7:0] ^ r_shift;
`endif
                end
              endcase
            end
          end else r_cnt <= r_cnt + CW'(1);
          default: r_state <= S_IDLE;
        endcase
      end

      if (r_wr_en) begin
        r_addr <= r_addr + ADDR_W'(1);
        r_wcnt <= r_wcnt + WCW'(1);
`ifndef LOADER_CHECKSUM_EN
        if (r_wcnt == WCW'(NUM_WORDS - 1)) r_done <= 1'b1;
`endif
      end
    end
  end

  assign bus.wr_en     = r_wr_en;
  assign bus.wr_addr   = r_addr;
  assign bus.wr_data   = r_wr_data;
  assign bus.busy      = (r_state != S_IDLE) || (r_idx != 2'd0);
  assign bus.done      = r_done;
  assign bus.frame_err = r_ferr;
endmodule

// File: tb/tb_uart_inst_loader.sv
// Directed bench for uart_inst_loader at 10 clks/bit, 2 words per session.
module tb_uart_inst_loader;
  localparam int CPB = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  uart_inst_loader_if #(.ADDR_W(8)) bus();

  uart_inst_loader #(.CLK_FREQ(1000), .BAUD(100), .ADDR_W(8), .NUM_WORDS(2)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          wr_cyc[$];
  logic [7:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          done_cyc = -1;
  int          last_t0 = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      wr_cyc.push_back(cyc);
      wr_addr_q.push_back(bus.wr_addr);
      wr_data_q.push_back(bus.wr_data);
    end
    if (bus.done === 1'b1 && done_cyc < 0) done_cyc = cyc;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Stop sample lands 98 cycles after start bit: 3 (sync + detect) + 5 (half) + 80 + 10.
  task automatic send_byte(input logic [7:0] b, input logic stop, input int drop_bit);
    last_t0 = cyc;
    bus.rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      bus.rx = b[i];
      if (i == drop_bit) begin
        tick(2);
        bus.en = 1'b0;
        tick(CPB - 2);
      end else tick(CPB);
    end
    bus.rx = stop;
    tick(CPB);
    bus.rx = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.rx = 1'b1;
    bus.en = 1'b1;
    tick(2);
    wr_cyc.delete();
    wr_addr_q.delete();
    wr_data_q.delete();
    done_cyc = -1;
    rst = 1'b1;
    tick(2);
  endtask

  task automatic test_reset();
    bus.rx = 1'b1;
    bus.en = 1'b1;
    rst = 1'b0;
    tick(3);
    n_chk++;
    if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.busy, bus.done, bus.frame_err, bus.chk_err} !== 45'd0)
      $display("FAIL reset_outputs: got wr_en=%b addr=%h data=%h busy=%b done=%b ferr=%b chk=%b, want all 0",
               bus.wr_en, bus.wr_addr, bus.wr_data, bus.busy, bus.done, bus.frame_err, bus.chk_err);
    else n_pass++;
    do_reset();
    n_chk++;
    if (bus.busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", bus.busy); else n_pass++;
  endtask

  task automatic test_single_word();
    logic [7:0] bytes [4] = '{8'h20, 8'h08, 8'h00, 8'h05};
    do_reset();
    foreach (bytes[i]) send_byte(bytes[i], 1'b1, -1);
    tick(3);
    n_chk++;
    if (wr_cyc.size() !== 1) $display("FAIL w1_count: got %0d want 1", wr_cyc.size()); else n_pass++;
    n_chk++;
    if (wr_addr_q[0] !== 8'h00 || wr_data_q[0] !== 32'h20080005)
      $display("FAIL w1_word: got addr=%h data=%h want 00/20080005", wr_addr_q[0], wr_data_q[0]);
    else n_pass++;
    n_chk++;
    if (wr_cyc[0] !== last_t0 + 98)
      $display("FAIL w1_timing: got cycle %0d want %0d", wr_cyc[0], last_t0 + 98);
    else n_pass++;
    n_chk++;
    if (bus.busy !== 1'b0 || bus.wr_en !== 1'b0)
      $display("FAIL w1_after: got busy=%b wr_en=%b want 0/0", bus.busy, bus.wr_en);
    else n_pass++;
    n_chk++;
    if (bus.wr_data !== 32'h20080005) $display("FAIL w1_hold: got %h want 20080005", bus.wr_data);
    else n_pass++;
  endtask

  task automatic send_eight();
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b1, -1);
    tick(3);
  endtask

  task automatic test_session();
    do_reset();
    send_eight();
    n_chk++;
    if (wr_cyc.size() !== 2) $display("FAIL s_count: got %0d want 2", wr_cyc.size()); else n_pass++;
    n_chk++;
    if (wr_addr_q[0] !== 8'h00 || wr_data_q[0] !== 32'h01020304)
      $display("FAIL s_word0: got addr=%h data=%h want 00/01020304", wr_addr_q[0], wr_data_q[0]);
    else n_pass++;
    n_chk++;
    if (wr_addr_q[1] !== 8'h01 || wr_data_q[1] !== 32'h05060708)
      $display("FAIL s_word1: got addr=%h data=%h want 01/05060708", wr_addr_q[1], wr_data_q[1]);
    else n_pass++;
`ifndef LOADER_CHECKSUM_EN
    n_chk++;
    if (bus.done !== 1'b1) $display("FAIL s_done: got %b want 1", bus.done); else n_pass++;
    n_chk++;
    if (done_cyc !== wr_cyc[1] + 1)
      $display("FAIL s_done_timing: got cycle %0d want %0d", done_cyc, wr_cyc[1] + 1);
    else n_pass++;
    for (int i = 9; i <= 12; i++) send_byte(8'(i), 1'b1, -1);
    tick(3);
    n_chk++;
    if (wr_cyc.size() !== 2 || bus.busy !== 1'b0)
      $display("FAIL s_after_done: got writes=%0d busy=%b want 2/0", wr_cyc.size(), bus.busy);
    else n_pass++;
`else
    n_chk++;
    if (bus.done !== 1'b0) $display("FAIL s_done_waits_ck: got %b want 0", bus.done); else n_pass++;
`endif
  endtask

  task automatic test_frame_err();
    do_reset();
    send_byte(8'h11, 1'b1, -1);
    send_byte(8'h22, 1'b1, -1);
    send_byte(8'h33, 1'b0, -1);
    tick(20);
    n_chk++;
    if (bus.frame_err !== 1'b1 || bus.busy !== 1'b0)
      $display("FAIL fe_flag: got ferr=%b busy=%b want 1/0", bus.frame_err, bus.busy);
    else n_pass++;
    send_byte(8'hAA, 1'b1, -1);
    send_byte(8'hBB, 1'b1, -1);
    send_byte(8'hCC, 1'b1, -1);
    send_byte(8'hDD, 1'b1, -1);
    tick(3);
    n_chk++;
    if (wr_cyc.size() !== 1 || wr_addr_q[0] !== 8'h00 || wr_data_q[0] !== 32'hAABBCCDD)
      $display("FAIL fe_word: got n=%0d addr=%h data=%h want 1/00/AABBCCDD",
               wr_cyc.size(), wr_addr_q[0], wr_data_q[0]);
    else n_pass++;
    n_chk++;
    if (bus.frame_err !== 1'b1) $display("FAIL fe_sticky: got %b want 1", bus.frame_err); else n_pass++;
  endtask

  task automatic test_glitch();
    do_reset();
    bus.rx = 1'b0;
    tick(3);
    n_chk++;
    if (bus.busy !== 1'b1) $display("FAIL gl_seen: got busy=%b want 1", bus.busy); else n_pass++;
    bus.rx = 1'b1;
    tick(6);
    n_chk++;
    if (bus.busy !== 1'b0) $display("FAIL gl_busy: got busy=%b want 0", bus.busy); else n_pass++;
    for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1, -1);
    tick(3);
    n_chk++;
    if (wr_cyc.size() !== 1 || wr_data_q[0] !== 32'h01020304)
      $display("FAIL gl_word: got n=%0d data=%h want 1/01020304", wr_cyc.size(), wr_data_q[0]);
    else n_pass++;
  endtask

  task automatic test_en_drop();
    do_reset();
    send_byte(8'h11, 1'b1, -1);
    send_byte(8'h22, 1'b1, -1);
    send_byte(8'h33, 1'b1, 4);
    tick(2);
    n_chk++;
    if (bus.busy !== 1'b0 || wr_cyc.size() !== 0)
      $display("FAIL en_abort: got busy=%b writes=%0d want 0/0", bus.busy, wr_cyc.size());
    else n_pass++;
    bus.en = 1'b1;
    tick(2);
    send_byte(8'hDE, 1'b1, -1);
    send_byte(8'hAD, 1'b1, -1);
    send_byte(8'hBE, 1'b1, -1);
    send_byte(8'hEF, 1'b1, -1);
    tick(3);
    n_chk++;
    if (wr_cyc.size() !== 1 || wr_addr_q[0] !== 8'h00 || wr_data_q[0] !== 32'hDEADBEEF)
      $display("FAIL en_word: got n=%0d addr=%h data=%h want 1/00/DEADBEEF",
               wr_cyc.size(), wr_addr_q[0], wr_data_q[0]);
    else n_pass++;
  endtask

  task automatic test_reset_midframe();
    bus.rx = 1'b0;
    tick(30);
    n_chk++;
    if (bus.busy !== 1'b1 || bus.wr_addr !== 8'h01)
      $display("FAIL rm_pre: got busy=%b addr=%h want 1/01", bus.busy, bus.wr_addr);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_chk++;
    if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.busy, bus.done, bus.frame_err, bus.chk_err} !== 45'd0)
      $display("FAIL rm_outputs: got wr_en=%b addr=%h data=%h busy=%b done=%b ferr=%b chk=%b, want all 0",
               bus.wr_en, bus.wr_addr, bus.wr_data, bus.busy, bus.done, bus.frame_err, bus.chk_err);
    else n_pass++;
    tick(3);
    bus.rx = 1'b1;
    rst = 1'b1;
    tick(2);
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    do_reset();
    send_eight();
    send_byte(8'h08, 1'b1, -1);
    tick(3);
    n_chk++;
    if (bus.done !== 1'b1 || bus.chk_err !== 1'b0)
      $display("FAIL ck_good: got done=%b chk=%b want 1/0", bus.done, bus.chk_err);
    else n_pass++;
    do_reset();
    send_eight();
    send_byte(8'h09, 1'b1, -1);
    tick(3);
    n_chk++;
    if (bus.done !== 1'b1 || bus.chk_err !== 1'b1)
      $display("FAIL ck_bad: got done=%b chk=%b want 1/1", bus.done, bus.chk_err);
    else n_pass++;
  endtask
`endif

  initial begin
    bus.rx = 1'b1;
    bus.en = 1'b1;
    test_reset();
    test_single_word();
    test_session();
    test_frame_err();
    test_glitch();
    test_en_drop();
    test_reset_midframe();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
